lfsr_draw_arbiter: RTL and testbench

Shares one 16-bit Galois LFSR random-number source among NREQ requesters. Round-robin arbitration grants at most one draw per cycle, and each granted draw advances the LFSR exactly once. The block also sequences the generator: it runs a post-reset/post-reseed warm-up and supports runtime seed loading. It sits between the RNG datapath and its consumers (game logic, test-pattern units).

---
 rtl/lfsr_draw_arbiter.sv | 142 ++++++++++++++
 tb/tb_lfsr_draw_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_draw_arbiter.sv
// Round-robin arbiter sharing one 16-bit Galois LFSR (mask 16'hB400) among NREQ requesters, with warm-up and seed load.
// Latency: req sampled -> registered ack/rnd_data one cycle later; at most one draw per cycle.
// Backpressure: req is level-held until ack; requests are ignored (kept pending) while busy. Optional: REPEAT_CHECK_EN.
module lfsr_draw_arbiter #(
    parameter int          NREQ          = 4,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          WARMUP_CYCLES = 4,
    localparam int         IDW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            seed_load,
    input  logic [15:0]     seed_value,
    output logic [NREQ-1:0] ack,
    output logic [15:0]     rnd_data,
    output logic [IDW-1:0]  gnt_id,
`ifdef REPEAT_CHECK_EN
    output logic            repeat_err,
`endif
    output logic            busy
);

    typedef enum logic {WARM = 1'b0, SERVE = 1'b1} state_t;

    localparam state_t     START_STATE = (WARMUP_CYCLES > 0) ? WARM : SERVE;
    localparam logic       START_BUSY  = (WARMUP_CYCLES > 0);
    localparam logic [7:0] WARM_LAST   = 8'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [15:0]       lfsr_q;
    logic [IDW-1:0]    ptr_q;
    logic [NREQ-1:0]   ack_q;
    logic [15:0]       rnd_q;
    logic [IDW-1:0]    gnt_q;
    logic              busy_q;
`ifdef REPEAT_CHECK_EN
    logic [15:0]       prev_q;
    logic              rep_err_q;
`endif

    logic [15:0]       lfsr_d;
    logic [15:0]       seed_d;
    logic              hit;
    logic [IDW-1:0]    hit_idx;
    logic [NREQ-1:0]   grant_oh;

    assign lfsr_d = lfsr_step(lfsr_q);
    // A zero seed would lock the LFSR at zero forever.
    assign seed_d = (seed_value == 16'h0000) ? SEED : seed_value;

    always_comb begin
        int             j;
        logic [IDW-1:0] idx;
        hit      = 1'b0;
        hit_idx  = '0;
        grant_oh = '0;
        j        = 0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            j   = (int'(ptr_q) + 1 + i) % NREQ;
            idx = IDW'(j);
            if (!hit && req[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
        grant_oh[hit_idx] = hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= START_STATE;
            cnt_q     <= '0;
            lfsr_q    <= SEED;
            ptr_q     <= IDW'(NREQ - 1);
            ack_q     <= '0;
            rnd_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= START_BUSY;
`ifdef REPEAT_CHECK_EN
            prev_q    <= '0;
            rep_err_q <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            if (seed_load) begin
                lfsr_q    <= seed_d;
                cnt_q     <= '0;
                state_q   <= START_STATE;
                busy_q    <= START_BUSY;
`ifdef REPEAT_CHECK_EN
                prev_q    <= '0;
                rep_err_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    WARM: begin
                        lfsr_q <= lfsr_d;
                        if (cnt_q == WARM_LAST) begin
                            cnt_q   <= '0;
                            state_q <= SERVE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    SERVE: begin
                        if (hit) begin
                            lfsr_q <= lfsr_d;
                            ack_q  <= grant_oh;
                            gnt_q  <= hit_idx;
                            rnd_q  <= lfsr_d;
                            ptr_q  <= hit_idx;
`ifdef REPEAT_CHECK_EN
                            prev_q <= lfsr_d;
                            if (lfsr_d == prev_q) begin
                                rep_err_q <= 1'b1;
                            end
`endif
                        end
                    end
                    default: state_q <= SERVE;
                endcase
            end
        end
    end

    assign ack      = ack_q;
    assign rnd_data = rnd_q;
    assign gnt_id   = gnt_q;
    assign busy     = busy_q;
`ifdef REPEAT_CHECK_EN
    assign repeat_err = rep_err_q;
`endif

endmodule

// File: tb/tb_lfsr_draw_arbiter.sv
// Directed bench for lfsr_draw_arbiter with default parameters; expected LFSR values hand-stepped from mask 16'hB400.
module tb_lfsr_draw_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        seed_load;
    logic [15:0] seed_value;
    logic [3:0]  ack;
    logic [15:0] rnd_data;
    logic [1:0]  gnt_id;
    logic        busy;
`ifdef REPEAT_CHECK_EN
    logic        repeat_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_draw_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .ack        (ack),
        .rnd_data   (rnd_data),
        .gnt_id     (gnt_id),
`ifdef REPEAT_CHECK_EN
        .repeat_err (repeat_err),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic busy_e);
        chk({tag, ".ack"}, 32'(ack), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'(busy_e));
    endtask

    task automatic chk_draw(input string tag, input logic [3:0] ack_e, input logic [1:0] gnt_e,
                            input logic [15:0] rnd_e);
        chk({tag, ".ack"}, 32'(ack), 32'(ack_e));
        chk({tag, ".gnt"}, 32'(gnt_id), 32'(gnt_e));
        chk({tag, ".rnd"}, 32'(rnd_data), 32'(rnd_e));
        chk({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    logic [3:0]  rr_ack [5];
    logic [15:0] rr_rnd [5];

    initial begin
        rst        = 1'b0;
        req        = 4'b0000;
        seed_load  = 1'b0;
        seed_value = 16'h0000;
        rr_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_rnd = '{16'h0E27, 16'hB313, 16'hED89, 16'hC2C4, 16'h6162};

        #12;
        chk("rst.ack", 32'(ack), 32'h0);
        chk("rst.rnd", 32'(rnd_data), 32'h0);
        chk("rst.gnt", 32'(gnt_id), 32'h0);
        chk("rst.busy", 32'(busy), 32'h1);
`ifdef REPEAT_CHECK_EN
        chk("rst.rep", 32'(repeat_err), 32'h0);
`endif
        rst = 1'b1;

        // Warm-up: four LFSR steps ACE1 -> 1C4E, busy for all of them.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("warm0", 1'b1);
        end
        step();
        chk_idle("warm0.end", 1'b0);

        // All requesters held: rotation from req[0].
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_draw("rr", rr_ack[i], 2'(i % 4), rr_rnd[i]);
        end
        req = 4'b0000;
        step();
        chk_idle("hold", 1'b0);
        chk("hold.rnd", 32'(rnd_data), 32'h6162);

        req = 4'b0001;
        step();
        chk_draw("single0", 4'b0001, 2'd0, 16'h30B1);
        req = 4'b0000;

        // Zero seed load beats a same-cycle request; substitute seed is used.
        seed_load  = 1'b1;
        seed_value = 16'h0000;
        req        = 4'b0100;
        step();
        chk_idle("seed0", 1'b1);
        seed_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("seed0.warm", 1'b1);
        end
        step();
        chk_idle("seed0.end", 1'b0);
        step();
        chk_draw("seed0.draw", 4'b0100, 2'd2, 16'h0E27);
        req = 4'b0000;

        // Seed 0001, reloaded mid warm-up: count restarts.
        seed_load  = 1'b1;
        seed_value = 16'h0001;
        step();
        chk_idle("seed1", 1'b1);
        seed_load = 1'b0;
        step();
        step();
        chk_idle("seed1.mid", 1'b1);
        seed_load = 1'b1;
        step();
        chk_idle("seed1.reload", 1'b1);
        seed_load = 1'b0;
        req       = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("seed1.warm", 1'b1);
        end
        step();
        chk_idle("seed1.end", 1'b0);
        step();
        chk_draw("seed1.draw", 4'b1000, 2'd3, 16'h0B40);
        req = 4'b0000;
        step();
        chk_idle("seed1.idle", 1'b0);

        // Async reset in the middle of a draw.
        req = 4'b0110;
        step();
        chk_draw("pre_rst", 4'b0010, 2'd1, 16'h05A0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.ack", 32'(ack), 32'h0);
        chk("arst.rnd", 32'(rnd_data), 32'h0);
        chk("arst.gnt", 32'(gnt_id), 32'h0);
        chk("arst.busy", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("warm2", 1'b1);
        end
        step();
        chk_idle("warm2.end", 1'b0);
        step();
        chk_draw("post_rst1", 4'b0010, 2'd1, 16'h0E27);
        step();
        chk_draw("post_rst2", 4'b0100, 2'd2, 16'hB313);
        req = 4'b0000;
        step();
        chk_idle("final", 1'b0);

`ifdef REPEAT_CHECK_EN
        req = 4'b1111;
        for (int i = 0; i < 1000; i++) begin
            step();
        end
        req = 4'b0000;
        step();
        chk("repeat_err", 32'(repeat_err), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
